// File: rtl/divider_8.sv
// Programmable clock divider: clk_div = clk / N for N in 2..15, 50% duty.
// Odd ratios stretch the high phase by half a clk cycle using a negedge register.
module divider_8 #(
  parameter int CLK_HZ = 100_000_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] sel_8,
  output logic       clk_div
);

  logic [3:0] cnt;
  logic [3:0] n_lat;
  logic [3:0] n_req;
  logic [3:0] cnt_nxt;
  logic [3:0] half;
  logic       idle;
  logic       ph_p;
  logic       ph_n;
  logic       period_end;

  // A request of 1 is clamped up to the minimum usable ratio of 2.
  function automatic logic [3:0] eff_ratio(input logic [3:0] sel);
    return (sel == 4'd1) ? 4'd2 : sel;
  endfunction

  assign n_req      = eff_ratio(sel_8);
  assign cnt_nxt    = cnt + 4'd1;
  assign half       = n_lat >> 1;
  assign period_end = idle || (cnt == n_lat - 4'd1);

  // Posedge stage: the ratio is latched only at a period boundary, so a
  // mid-period change of sel_8 never shortens the pulse in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt   <= 4'd0;
      n_lat <= 4'd2;
      idle  <= 1'b1;
      ph_p  <= 1'b0;
    end else if (period_end) begin
      cnt <= 4'd0;
      if (n_req == 4'd0) begin
        idle <= 1'b1;
        ph_p <= 1'b0;
      end else begin
        idle  <= 1'b0;
        n_lat <= n_req;
        ph_p  <= 1'b1;
      end
    end else begin
      cnt  <= cnt_nxt;
      ph_p <= (cnt_nxt < half);
    end
  end

  // Negedge stage: for odd N, holds the output high half a cycle past ph_p.
  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ph_n <= 1'b0;
    end else begin
      ph_n <= ph_p & n_lat[0];
    end
  end

  assign clk_div = ph_p | ph_n;

endmodule

// File: tb/tb_divider_8.sv
// Scoreboard bench for divider_8: stimulus queues expected periods, a monitor
// measures each clk_div period/high time and compares against the queue.
`timescale 1ns/1ps
module tb_divider_8;

  localparam int CLK_HZ = 100_000_000;

  logic       tb_clk;
  logic       rst_n;
  logic [3:0] sel_8;
  logic       tb_clk_div;

  divider_8 #(.CLK_HZ(CLK_HZ)) dut (
    .clk     (tb_clk),
    .rst_n   (rst_n),
    .sel_8   (sel_8),
    .clk_div (tb_clk_div)
  );

  initial tb_clk = 1'b0;
  always #5 tb_clk = ~tb_clk;

  typedef struct {
    int period_ns;
    int high_ns;
    bit fall_neg;
  } exp_t;

  exp_t    sb[$];
  int      checks;
  int      errors;
  int      rise_cnt;
  int      resync_req;
  int      resync_seen;
  int      cur_n;
  bit      have_prev;
  bit      fall_neg;
  realtime last_rise;
  realtime last_fall;

  task automatic push_exp(input int n, input int k);
    exp_t e;
    for (int i = 0; i < k; i++) begin
      e.period_ns = n * 10;
      e.high_ns   = n * 5;
      e.fall_neg  = (n % 2) == 1;
      sb.push_back(e);
    end
  endtask

  task automatic check_bit(input string name, input logic act, input logic req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: clk_div=%b required %b at %0t", name, act, req, $time);
    end
  endtask

  task automatic wait_rises(input int k);
    int target;
    int cyc;
    target = rise_cnt + k;
    cyc = 0;
    while (rise_cnt < target && cyc < 20 * k + 40) begin
      @(negedge tb_clk);
      cyc++;
    end
    checks++;
    if (rise_cnt < target) begin
      errors++;
      $display("FAIL rise_timeout: saw %0d rises required %0d", rise_cnt, target);
    end
  endtask

  // Called just after a rise: that period still runs at cur_n.
  task automatic seg(input int n, input int k);
    push_exp(cur_n, 1);
    sel_8 = 4'(n);
    push_exp(n, k);
    cur_n = n;
    wait_rises(k + 1);
  endtask

  task automatic start_run(input int n, input int k);
    push_exp(n, k);
    cur_n = n;
    wait_rises(k);
  endtask

  initial begin
    checks = 0; errors = 0; rise_cnt = 0;
    resync_req = 0; resync_seen = 0; have_prev = 0; fall_neg = 0;
    last_rise = 0; last_fall = 0; cur_n = 2;
    rst_n = 1'b1;
    sel_8 = 4'd2;
    fork
      begin : monitor
        int   per;
        int   hi;
        exp_t e;
        forever begin
          @(tb_clk_div);
          if (tb_clk_div === 1'b1) begin
            rise_cnt++;
            if (resync_req != resync_seen) begin
              resync_seen = resync_req;
              have_prev = 0;
            end
            if (have_prev) begin
              per = int'($realtime - last_rise);
              hi  = int'(last_fall - last_rise);
              checks++;
              if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_period: period %0d ns high %0d ns, nothing queued", per, hi);
              end else begin
                e = sb.pop_front();
                $display("info: period %0d ns high %0d ns duty %0.2f%% freq %0d Hz",
                         per, hi, 100.0 * hi / per, 1000000000 / per);
                if (per != e.period_ns || hi != e.high_ns || fall_neg != e.fall_neg || tb_clk !== 1'b1)
                begin
                  errors++;
                  $display("FAIL period_check: period %0d high %0d fall_on_neg %0d rise_clk %b, required period %0d high %0d fall_on_neg %0d rise_clk 1",
                           per, hi, fall_neg, tb_clk, e.period_ns, e.high_ns, e.fall_neg);
                end
              end
            end
            last_rise = $realtime;
            have_prev = 1;
          end else if (tb_clk_div === 1'b0) begin
            last_fall = $realtime;
            fall_neg  = (tb_clk == 1'b0);
          end
        end
      end
      begin : stimulus
        // Reset held ~200 ns with N=2.
        #1 rst_n = 1'b0;
        #50 check_bit("reset_low_a", tb_clk_div, 1'b0);
        #50 check_bit("reset_low_b", tb_clk_div, 1'b0);
        #50 check_bit("reset_low_c", tb_clk_div, 1'b0);
        #50;
        @(negedge tb_clk) rst_n = 1'b1;
        @(posedge tb_clk) #1 check_bit("first_rise_after_reset", tb_clk_div, 1'b1);
        start_run(2, 3);

        seg(4, 3);
        seg(8, 3);
        seg(10, 3);
        seg(5, 3);

        // Disable: the running N=5 period finishes, then the output stays low.
        sel_8 = 4'd0;
        #55;
        for (int i = 0; i < 5; i++) begin
          check_bit("disabled_low", tb_clk_div, 1'b0);
          #30;
        end
        resync_req++;
        @(negedge tb_clk) sel_8 = 4'd1;
        @(posedge tb_clk) #1 check_bit("enable_first_rise", tb_clk_div, 1'b1);
        start_run(2, 3);

        seg(15, 2);
        seg(10, 2);

        // Reset pulse during the high phase of an N=10 period.
        #18;
        resync_req++;
        rst_n = 1'b0;
        #1 check_bit("reset_mid_high", tb_clk_div, 1'b0);
        #30 check_bit("reset_hold_low", tb_clk_div, 1'b0);
        @(negedge tb_clk) rst_n = 1'b1;
        @(posedge tb_clk) #1 check_bit("rise_after_mid_reset", tb_clk_div, 1'b1);
        start_run(10, 2);

        checks++;
        if (sb.size() != 0) begin
          errors++;
          $display("FAIL scoreboard_drain: %0d expectations left, required 0", sb.size());
        end
      end
    join_any
    disable fork;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
